pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 32-bit pipeline.
- Drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB (MWBuffer) stage registers.
- Detects load-use hazards and flushes on taken branches.
- Freezes the whole pipeline while a data-memory access waits on a ready handshake, with timeout detection.

Parameters:
REG_ADDR_W, 5, register-file address width
WAIT_MAX, 15, max MEM_WAIT cycles before timeout (1..2^WAIT_W-1)
WAIT_W, 4, width of wait counter
PERF_W, 16, width of performance counters (PERF_CNT_EN only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
idRs_i  in  REG_ADDR_W  rs of instruction in ID
idRt_i  in  REG_ADDR_W  rt of instruction in ID
exMemRead_i  in  1  instruction in EX is a load
exWriteAddrReg_i  in  REG_ADDR_W  destination register of EX instruction
branchTaken_i  in  1  EX resolved a taken branch/jump
memAccess_i  in  1  MEM-stage instruction reads or writes data memory
memReady_i  in  1  data memory completes access this cycle
pcWrite_o  out  1  PC update enable
ifIdWrite_o  out  1  IF/ID load enable
ifIdFlush_o  out  1  IF/ID clear to NOP
idExFlush_o  out  1  ID/EX clear to bubble
exMemWrite_o  out  1  EX/MEM load enable
mwWrite_o  out  1  MEM/WB load enable
memReq_o  out  1  data-memory request strobe
memTimeout_o  out  1  sticky timeout error flag
stallCycles_o  out  PERF_W  total frozen/stalled cycles
flushCount_o  out  PERF_W  number of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR.
- Reset: state=RUN, wait counter=0, memTimeout_o=0, perf counters=0.
  - While rst_i is high, all write enables, flushes and memReq_o are 0.
  - Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately.
- Outputs are combinational from registered state plus current inputs. No added latency.
- freeze = (state==RUN && memAccess_i && !memReady_i) || state==MEM_WAIT && !memReady_i || state==ERROR.
- memReq_o = memAccess_i && state!=ERROR.
- RUN:
  - memAccess_i && !memReady_i: freeze; next=MEM_WAIT; counter<=1.
  - memAccess_i && memReady_i, or !memAccess_i: no freeze; stay in RUN.
- MEM_WAIT:
  - memReady_i: release (enables per priority rules below); next=RUN; counter<=0.
  - !memReady_i && counter==WAIT_MAX: next=ERROR; memTimeout_o<=1.
  - Otherwise counter++.
- ERROR: frozen permanently; exits only via rst_i.
- Priority when not frozen:
  - branchTaken_i: ifIdFlush_o=1, idExFlush_o=1; pcWrite_o, ifIdWrite_o, exMemWrite_o and mwWrite_o all 1.
    - Overrides load-use, because the younger instruction is discarded.
  - Else, load-use when exMemRead_i && exWriteAddrReg_i!=0 && (exWriteAddrReg_i==idRs_i || exWriteAddrReg_i==idRt_i):
    - pcWrite_o=0, ifIdWrite_o=0, idExFlush_o=1; exMemWrite_o=mwWrite_o=1.
    - Exactly one bubble: next cycle the load is in MEM and the comparison no longer matches.
  - Else: all enables 1, all flushes 0.
- Frozen: all enables 0, all flushes 0.
  - A branchTaken_i seen during a freeze stays held by the frozen ID/EX and is applied in the release cycle.
- Register $0 never causes a stall.

Optional Feature:
PERF_CNT_EN
- Defined:
  - stallCycles_o increments each cycle with freeze or load-use stall.
  - flushCount_o increments on each applied branch flush.
  - Both saturate at all-ones; both cleared by rst_i.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Load to r5 in EX, idRs_i=5 -> one cycle of pcWrite_o=0, ifIdWrite_o=0, idExFlush_o=1, then all enables 1.
- Load to r0 in EX, idRt_i=0 -> no stall; all enables 1.
- memAccess_i=1, memReady_i low 3 cycles then high -> enables 0 for 3 cycles, release in cycle 4; stallCycles_o=3 with PERF_CNT_EN.
- branchTaken_i=1 together with a load-use match -> ifIdFlush_o=idExFlush_o=1, pcWrite_o=1; flushCount_o=1.
- memReady_i held low with WAIT_MAX=15 -> ERROR after 16 frozen cycles, memTimeout_o=1 until rst_i pulse; rst_i returns all outputs to reset values asynchronously.
- branchTaken_i during MEM_WAIT -> flushes asserted only in the memReady_i release cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Generates PC / IF/ID / ID/EX / EX/MEM / MEM/WB enables and flushes. It handles
// load-use hazards, taken-branch flushes and data-memory wait freezes, and
// detects a memory timeout.
// Optional build macro: PERF_CNT_EN adds saturating stall/flush counters.
// Without it, stallCycles_o and flushCount_o are tied to zero.
//
// Memory handshake: memReq_o follows memAccess_i, except in ERROR. An access
// completes in the cycle where memAccess_i (or an outstanding MEM_WAIT) and
// memReady_i are both high. Until then the pipeline is frozen. memReady_i may
// rise in any cycle, and no request is dropped while it stays low.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int WAIT_MAX   = 15,
  parameter int WAIT_W     = 4,
  parameter int PERF_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] idRs_i,
  input  logic [REG_ADDR_W-1:0] idRt_i,
  input  logic                  exMemRead_i,
  input  logic [REG_ADDR_W-1:0] exWriteAddrReg_i,
  input  logic                  branchTaken_i,
  input  logic                  memAccess_i,
  input  logic                  memReady_i,
  output logic                  pcWrite_o,
  output logic                  ifIdWrite_o,
  output logic                  ifIdFlush_o,
  output logic                  idExFlush_o,
  output logic                  exMemWrite_o,
  output logic                  mwWrite_o,
  output logic                  memReq_o,
  output logic                  memTimeout_o,
  output logic [PERF_W-1:0]     stallCycles_o,
  output logic [PERF_W-1:0]     flushCount_o,
  output logic [1:0]            stateDbg_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_t            state;
  state_t            stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitCntNext;
  logic              timeoutQ;
  logic              timeoutNext;
  logic              freeze;
  logic              loadUse;

  // Hazard and freeze detection from registered state and current inputs.
  // Register $0 is hardwired to zero, so a load to it never stalls.
  always_comb begin
    loadUse = exMemRead_i && (exWriteAddrReg_i != '0) &&
              ((exWriteAddrReg_i == idRs_i) || (exWriteAddrReg_i == idRt_i));
    freeze  = ((state == RUN) && memAccess_i && !memReady_i) ||
              ((state == MEM_WAIT) && !memReady_i) ||
              (state == ERROR);
  end

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitCntNext;
      timeoutQ <= timeoutNext;
    end
  end

  // Next-state logic and stage controls. Outputs are forced low while reset is held.
  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    timeoutNext  = timeoutQ;
    pcWrite_o    = 1'b0;
    ifIdWrite_o  = 1'b0;
    ifIdFlush_o  = 1'b0;
    idExFlush_o  = 1'b0;
    exMemWrite_o = 1'b0;
    mwWrite_o    = 1'b0;
    memReq_o     = 1'b0;

    case (state)
      RUN: begin
        if (memAccess_i && !memReady_i) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memReady_i) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == WAIT_LIMIT) begin
          stateNext   = ERROR;
          timeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        stateNext = ERROR;
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase

    if (!rst_i) begin
      memReq_o = memAccess_i && (state != ERROR);
      if (!freeze) begin
        if (branchTaken_i) begin
          // The younger instruction is discarded anyway, so the branch wins over load-use.
          pcWrite_o    = 1'b1;
          ifIdWrite_o  = 1'b1;
          ifIdFlush_o  = 1'b1;
          idExFlush_o  = 1'b1;
          exMemWrite_o = 1'b1;
          mwWrite_o    = 1'b1;
        end else if (loadUse) begin
          // One bubble: next cycle the load is in MEM and no longer matches.
          idExFlush_o  = 1'b1;
          exMemWrite_o = 1'b1;
          mwWrite_o    = 1'b1;
        end else begin
          pcWrite_o    = 1'b1;
          ifIdWrite_o  = 1'b1;
          exMemWrite_o = 1'b1;
          mwWrite_o    = 1'b1;
        end
      end
    end
  end

  assign memTimeout_o = timeoutQ;
  assign stateDbg_o   = state;

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] stallCnt;
  logic [PERF_W-1:0] flushCnt;
  logic              stallEvent;
  logic              flushEvent;

  // A stall cycle is either a freeze or an applied load-use bubble.
  always_comb begin
    stallEvent = freeze || (loadUse && !branchTaken_i);
    flushEvent = !freeze && branchTaken_i;
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEvent && (stallCnt != '1)) stallCnt <= stallCnt + PERF_W'(1);
      if (flushEvent && (flushCnt != '1)) flushCnt <= flushCnt + PERF_W'(1);
    end
  end

  assign stallCycles_o = stallCnt;
  assign flushCount_o  = flushCnt;
`else
  assign stallCycles_o = '0;
  assign flushCount_o  = '0;
`endif

endmodule
